// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller: sequences a handshaked program load into the
// external single-port array, then releases the CPU and serves registered, checked fetches.
module imem_access_ctrl #(
   parameter int          ADDR_W    = 6,
   parameter int          DEPTH     = 62,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic [ADDR_W:0]   load_count,
   output logic              load_overflow,
   output logic              cpu_run,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_fault,
   output logic              fetch_stall,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [29:0]     DEPTH_IDX = 30'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};

   state_t            state_r, state_next_s;
   logic [ADDR_W-1:0] wptr_r, wptr_next_s;
   logic [ADDR_W:0]   count_r, count_next_s, count_inc_s;
   logic              ovf_r, ovf_next_s;
   logic              cpu_run_r;
   logic              word_acc_s;
   logic              fetch_acc_s;
   logic              fetch_bad_s;
   logic              fetch_valid_r;
   logic [31:0]       fetch_instr_r;
   logic              fetch_fault_r;

   assign count_inc_s = count_r + CNT_ONE;

   // Next-state and load bookkeeping; a load_start from any state begins a fresh load.
   always_comb begin
      state_next_s = state_r;
      wptr_next_s  = wptr_r;
      count_next_s = count_r;
      ovf_next_s   = ovf_r;
      word_acc_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_RUN: begin
            if (load_start) begin
               state_next_s = ST_LOAD;
               wptr_next_s  = {ADDR_W{1'b0}};
               count_next_s = {(ADDR_W + 1){1'b0}};
               ovf_next_s   = 1'b0;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_LOAD: begin
            if (load_start) begin
               wptr_next_s  = {ADDR_W{1'b0}};
               count_next_s = {(ADDR_W + 1){1'b0}};
               ovf_next_s   = 1'b0;
            end else if (load_valid) begin
               word_acc_s   = 1'b1;
               wptr_next_s  = wptr_r + PTR_ONE;
               count_next_s = count_inc_s;
               if (load_last || (count_inc_s == DEPTH_CNT)) begin
                  state_next_s = ST_RUN;
                  // Memory filled without a terminating word: flag it sticky.
                  if (!load_last) begin
                     ovf_next_s = 1'b1;
                  end else begin
                     ovf_next_s = ovf_r;
                  end
               end else begin
                  state_next_s = ST_LOAD;
               end
            end else begin
               state_next_s = ST_LOAD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Memory port steering and fetch acceptance/check.
   always_comb begin
      fetch_acc_s = fetch_req && (state_r == ST_RUN) && !load_start;
      fetch_stall = fetch_req && !((state_r == ST_RUN) && !load_start);
      fetch_bad_s = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:2] >= DEPTH_IDX);
      load_ready  = (state_r == ST_LOAD);
      mem_we      = word_acc_s;
      mem_wdata   = load_data;
      if (state_r == ST_LOAD) begin
         mem_addr = wptr_r;
      end else begin
         mem_addr = fetch_addr[ADDR_W+1:2];
      end
   end

   // Controller state, load counters and the CPU release flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         wptr_r    <= {ADDR_W{1'b0}};
         count_r   <= {(ADDR_W + 1){1'b0}};
         ovf_r     <= 1'b0;
         cpu_run_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         wptr_r    <= wptr_next_s;
         count_r   <= count_next_s;
         ovf_r     <= ovf_next_s;
         cpu_run_r <= (state_next_s == ST_RUN);
      end
   end

   // Registered fetch response; instruction holds when no request was accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_valid_r <= 1'b0;
         fetch_instr_r <= 32'h0000_0000;
         fetch_fault_r <= 1'b0;
      end else begin
         fetch_valid_r <= fetch_acc_s;
         fetch_fault_r <= fetch_acc_s && fetch_bad_s;
         if (fetch_acc_s) begin
            fetch_instr_r <= fetch_bad_s ? NOP_INSTR : mem_rdata;
         end else begin
            fetch_instr_r <= fetch_instr_r;
         end
      end
   end

   assign load_count    = count_r;
   assign load_overflow = ovf_r;
   assign cpu_run       = cpu_run_r;
   assign fetch_valid   = fetch_valid_r;
   assign fetch_instr   = fetch_instr_r;
   assign fetch_fault   = fetch_fault_r;

endmodule
